// File: rtl/mult_scale_stage.sv
// mult_scale_stage: operand sequencer and result scaler for the mult16x16
// primitive (registered A/B, combinational product, 1-cycle latency).
// Two-slot pipeline: P tracks the multiplier product, O holds the scaled,
// saturated result presented downstream.
// Optional build macro: MULT_SCALE_SATCNT_EN adds sat_clr / sat_count.
module mult_scale_stage #(
  parameter int SHIFT = 8,
  parameter int OUT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_a,
  input  logic [15:0]       in_b,
  output logic [15:0]       mul_a,
  output logic [15:0]       mul_b,
  output logic              mul_ce,
  input  logic [31:0]       mul_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
`ifdef MULT_SCALE_SATCNT_EN
  ,
  input  logic              sat_clr,
  output logic [15:0]       sat_count
`endif
);

  // Rounding constant is 2^(SHIFT-1), or zero when nothing is dropped.
  localparam logic signed [32:0] ROUND_V = (33'sd1 <<< SHIFT) >>> 1;
  localparam logic signed [32:0] MAX_V   = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MIN_V   = -(33'sd1 <<< (OUT_W - 1));

  logic p_valid;
  logic p_take;
  logic accept;

  logic signed [32:0] prod_ext;
  logic signed [32:0] rounded;
  logic signed [32:0] shifted;
  logic [OUT_W-1:0]   sat_data;
  logic               sat_flag;

  // Handshake: P may advance into O whenever O is empty or draining.
  assign p_take   = p_valid & (~out_valid | out_ready);
  assign in_ready = ~p_valid | p_take;
  assign accept   = in_valid & in_ready;

  // Operands go straight to the multiplier; ce loads them only on accept,
  // so mul_dout stays stable while P waits.
  assign mul_a  = in_a;
  assign mul_b  = in_b;
  assign mul_ce = accept;

  // P slot: product valid one cycle after accept, held until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid <= 1'b0;
    end else begin
      p_valid <= accept | (p_valid & ~p_take);
    end
  end

  // Round half toward +inf, arithmetic shift, then clip to OUT_W.
  always_comb begin
    prod_ext = {mul_dout[31], mul_dout};
    rounded  = prod_ext + ROUND_V;
    shifted  = rounded >>> SHIFT;
    sat_flag = 1'b0;
    sat_data = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      sat_data = MAX_V[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (shifted < MIN_V) begin
      sat_data = MIN_V[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

  // O slot: reload on p_take (even while draining), else clear on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (p_take) begin
      out_valid <= 1'b1;
      out_data  <= sat_data;
      out_sat   <= sat_flag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MULT_SCALE_SATCNT_EN
  // Count clipped results as they are consumed; sticky at full scale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= 16'h0000;
    end else if (sat_clr) begin
      sat_count <= 16'h0000;
    end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/mult_scale_stage.md
Name: mult_scale_stage

Overview:
Downstream consumer and operand sequencer for the 16x16 signed multiplier primitive wrapper (mult16x16: registered A/B inputs, combinational output, 1-cycle latency). Accepts operand pairs over a valid/ready handshake and drives the multiplier's operand and ce pins. Captures the 32-bit signed product, applies an arithmetic right shift with round-half-up, and saturates to OUT_W bits. Presents the result over a valid/ready handshake; used for fixed-point pixel and coordinate scaling in the GbE-to-LCD path.

Parameters:
SHIFT, 8, fractional bits dropped from the product (0..16); SHIFT=0 means no rounding.
OUT_W, 16, signed result width (8..32).

Ports:
clk  input  1  system clock; also drives the multiplier clk.
reset  input  1  asynchronous, active-high; the top level also ties it to the multiplier reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  stage can accept an operand pair this cycle.
in_a  input  16  signed operand A.
in_b  input  16  signed operand B.
mul_a  output  16  to multiplier a; equals in_a, combinational.
mul_b  output  16  to multiplier b; equals in_b, combinational.
mul_ce  output  1  to multiplier ce.
mul_dout  input  32  signed product from the multiplier.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_data  output  OUT_W  scaled, saturated signed result.
out_sat  output  1  result was clipped; qualified by out_valid.

Behaviour:
- Reset (asynchronous, active-high): p_valid=0, out_valid=0, out_data=0, out_sat=0. Operands already held in the multiplier's input registers are don't-care after reset.
- accept = in_valid & in_ready. mul_ce = accept, so the multiplier input registers load only on accept.
- Stage P (product) tracks whether mul_dout is valid:
  - p_valid is set on the cycle after accept.
  - While mul_ce is low, the multiplier inputs hold, so mul_dout stays stable.
- p_take = p_valid & (~out_valid | out_ready).
- in_ready = ~p_valid | p_take. This is combinational from out_ready and local state; no path from in_valid to in_ready.
- Next p_valid = accept | (p_valid & ~p_take).
- Stage O (output register): on p_take, load out_data, load out_sat, and set out_valid.
  - When out_valid & out_ready & ~p_take, clear out_valid. out_data holds its last value.
- Latency: operands accepted in cycle N give out_valid in cycle N+2.
  - Sustained throughput is 1 result per clock while out_ready=1.
  - Under backpressure no result is lost or duplicated. At most 2 items are in flight (P and O).
- Arithmetic, evaluated on the 32-bit signed mul_dout:
  - Extend to 33 bits.
  - If SHIFT>0, add 2^(SHIFT-1).
  - Arithmetic shift right by SHIFT. This rounds half toward +infinity: -0.5 rounds to 0, +0.5 rounds to 1.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 when clipping occurs.
  - With SHIFT=0 and OUT_W=32 the result is bit-exact pass-through with no saturation.
- Boundary cases:
  - 0x8000*0x8000 = +2^30 must not wrap.
  - Simultaneous output drain and new product in the same cycle: O reloads and out_valid stays 1.
  - Reset asserted mid-transfer discards both stages. The first accept after reset release behaves exactly as the first after power-up.

Optional Feature:
MULT_SCALE_SATCNT_EN:
- Defined: adds output sat_count [15:0]. It counts results with out_sat=1 at the moment they are consumed (out_valid & out_ready). It sticks at 0xFFFF, resets to 0, and also clears on an added input sat_clr (1 bit, synchronous, priority over increment).
- Not defined: neither port exists and no counter logic is generated. Handshake and data behaviour are identical either way.

Test Plan:
- Defaults, out_ready=1. a=300, b=200 (product 60000) -> out_data=234, out_sat=0, out_valid exactly 2 cycles after accept.
- a=-1, b=128 (-128) -> out_data=0. a=-3, b=85 (-255) -> out_data=-1. a=1, b=128 (+128) -> out_data=1. Checks the round-half-up rule.
- a=-32768, b=-32768 -> out_data=32767, out_sat=1. a=-32768, b=32767 -> out_data=-32768, out_sat=1. No wrap.
- Back-to-back stream of 16 random pairs with out_ready toggling pseudo-randomly. Results must match a reference model in order with no loss or duplication. in_ready must drop only when P and O are both full and out_ready=0. mul_ce must equal accept every cycle.
- Assert reset for 1 cycle while both stages are full -> out_valid=0, out_data=0, in_ready=1 immediately. The next pair a=2, b=256 -> out_data=2.
- With MULT_SCALE_SATCNT_EN: 3 saturating and 2 non-saturating results consumed -> sat_count=3. sat_clr pulse -> 0. Without the macro the build succeeds and the sat_count port is absent.
